case_vector_gen: RTL and testbench

//  - Drive-side counterpart of the 2-digit four-state case decoders used as lint/sim targets.
//  - Walks the 16 two-digit {0,1,X,Z} patterns in table order and issues each one as a coded vector with its expected decode.
//  - Checks in-order DUT responses against those expectations and counts mismatches.
//  - Sits between the bench/top-level sequencer and any decoder under test.

---
 rtl/case_gen_pkg.sv | 26 ++
 rtl/case_gen_exp_fifo.sv | 56 +++++
 rtl/case_vector_gen.sv | 172 +++++++++++++++++
 tb/tb_case_vector_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_gen_pkg.sv
// Shared digit codes, pattern table and FSM states for the case vector generator.
// CASE_GEN_STICKY_ERR_EN widens expectations to carry the table index.
package case_gen_pkg;

   localparam logic [1:0] D0 = 2'b00;
   localparam logic [1:0] D1 = 2'b01;
   localparam logic [1:0] DX = 2'b10;
   localparam logic [1:0] DZ = 2'b11;

   // Entry i holds {msd,lsd} for table index i (index 15 listed first).
   localparam logic [15:0][3:0] PATTERN_LUT = {
      {DZ, DZ}, {DZ, DX}, {DZ, D1}, {DZ, D0},
      {DX, D0}, {DX, D1}, {DX, DZ}, {DX, DX},
      {D1, DX}, {D1, DZ}, {D1, D1}, {D1, D0},
      {D0, DZ}, {D0, DX}, {D0, D1}, {D0, D0}
   };

`ifdef CASE_GEN_STICKY_ERR_EN
   localparam int unsigned EXP_W = 5;
`else
   localparam int unsigned EXP_W = 1;
`endif

   typedef enum logic [2:0] {StIdle, StSend, StGap, StDrain, StDone} gen_state_e;

endpackage

// File: rtl/case_gen_exp_fifo.sv
// Synchronous expectation FIFO with flush; push and pop may coincide, even when full.
module case_gen_exp_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 1,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   // A full FIFO can accept a push only when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CW'(1);
         else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      end
   end

endmodule

// File: rtl/case_vector_gen.sv
// Issues the 16 two-digit four-state patterns as coded vectors and checks in-order responses.
// CASE_GEN_STICKY_ERR_EN: first mismatch latches err_idx_o and stops issuing.
module case_vector_gen
   import case_gen_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned NUM_PASSES = 1,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   output logic             vec_valid_o,
   input  logic             vec_ready_i,
   output logic [3:0]       vec_code_o,
   output logic [3:0]       vec_idx_o,
   output logic             vec_exp_o,
   input  logic             rsp_valid_i,
   input  logic             rsp_y_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [ERR_W-1:0] err_cnt_o,
`ifdef CASE_GEN_STICKY_ERR_EN
   output logic [3:0]       err_idx_o,
`endif
   output logic [7:0]       pass_cnt_o
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   gen_state_e       state_q;
   logic [3:0]       idx_q, code_q, idx_inc, gap_q;
   logic [7:0]       pass_q;
   logic [ERR_W-1:0] err_q;
   logic             busy_q, done_q;

   logic             xfer, restart, bypass, chk, mismatch, spurious, last, all_issued;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty, go_done;
   logic [EXP_W-1:0] push_data, fifo_rdata, chk_data;
   logic [CW-1:0]    fifo_count;

`ifdef CASE_GEN_STICKY_ERR_EN
   logic [3:0] err_idx_q;
   logic       err_lat_q;
   assign push_data = {idx_q, idx_q[0]};
   assign err_idx_o = err_idx_q;
`else
   assign push_data = idx_q[0];
`endif

   assign vec_valid_o = (state_q == StSend) && !fifo_full;
   assign vec_code_o  = code_q;
   assign vec_idx_o   = idx_q;
   assign vec_exp_o   = idx_q[0];
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_cnt_o   = err_q;
   assign pass_cnt_o  = pass_q;

   always_comb begin
      xfer       = vec_valid_o && vec_ready_i;
      restart    = start_i && ((state_q == StIdle) || (state_q == StDone));
      idx_inc    = idx_q + 4'd1;
      // A zero-latency response to an empty FIFO checks the vector being pushed.
      bypass     = rsp_valid_i && fifo_empty && xfer;
      fifo_push  = xfer && !bypass;
      fifo_pop   = rsp_valid_i && !fifo_empty;
      chk_data   = fifo_empty ? push_data : fifo_rdata;
      chk        = fifo_pop || bypass;
      mismatch   = chk && (rsp_y_i != chk_data[0]);
      spurious   = rsp_valid_i && fifo_empty && !xfer;
      last       = (idx_q == 4'hF) && ((pass_q + 8'd1) == 8'(NUM_PASSES));
      all_issued = (pass_q == 8'(NUM_PASSES));
      go_done    = fifo_empty || (fifo_pop && (fifo_count == CW'(1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         code_q    <= '0;
         pass_q    <= '0;
         gap_q     <= '0;
         err_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef CASE_GEN_STICKY_ERR_EN
         err_idx_q <= '0;
         err_lat_q <= 1'b0;
`endif
      end else begin
         if ((mismatch || spurious) && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + ERR_W'(1);
         end
`ifdef CASE_GEN_STICKY_ERR_EN
         if (mismatch && !err_lat_q) begin
            err_lat_q <= 1'b1;
            err_idx_q <= chk_data[4:1];
         end
`endif
         unique case (state_q)
            StIdle, StDone: begin
               if (restart) begin
                  state_q   <= StSend;
                  idx_q     <= '0;
                  code_q    <= PATTERN_LUT[0];
                  pass_q    <= '0;
                  gap_q     <= '0;
                  err_q     <= '0;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
`ifdef CASE_GEN_STICKY_ERR_EN
                  err_idx_q <= '0;
                  err_lat_q <= 1'b0;
`endif
               end
            end
            StSend: begin
               if (xfer) begin
                  idx_q  <= idx_inc;
                  code_q <= PATTERN_LUT[idx_inc];
                  if (idx_q == 4'hF) pass_q <= pass_q + 8'd1;
                  if (GAP_CYCLES > 0) begin
                     state_q <= StGap;
                     gap_q   <= '0;
                  end else if (last) begin
                     state_q <= StDrain;
                  end
               end
            end
            StGap: begin
               if (gap_q == 4'(GAP_CYCLES - 1)) begin
                  state_q <= all_issued ? StDrain : StSend;
               end else begin
                  gap_q <= gap_q + 4'd1;
               end
            end
            StDrain: begin
               if (go_done) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
`ifdef CASE_GEN_STICKY_ERR_EN
         if (mismatch && !err_lat_q && ((state_q == StSend) || (state_q == StGap))) begin
            state_q <= StDrain;
         end
`endif
      end
   end

   case_gen_exp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EXP_W)
   ) u_exp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (restart),
      .push_i  (fifo_push),
      .wdata_i (push_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_case_vector_gen.sv
// Bench for case_vector_gen: table-driven scoreboard of expected vectors plus corner sequences.
module tb_case_vector_gen;

   typedef struct packed {
      logic [3:0] idx;
      logic [3:0] code;
      logic       exp;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n, start, ready, rsp_valid, rsp_y, sel;
   always #5 clk = ~clk;

   logic       a_valid, a_exp, a_busy, a_done, b_valid, b_exp, b_busy, b_done;
   logic [3:0] a_code, a_idx, b_code, b_idx;
   logic [7:0] a_err, a_pass, b_err, b_pass;
`ifdef CASE_GEN_STICKY_ERR_EN
   logic [3:0] a_err_idx, b_err_idx;
`endif

   logic       obs_valid, obs_exp, obs_done;
   logic [3:0] obs_code, obs_idx;
   logic [7:0] obs_err, obs_pass;
   assign obs_valid = sel ? b_valid : a_valid;
   assign obs_exp   = sel ? b_exp   : a_exp;
   assign obs_done  = sel ? b_done  : a_done;
   assign obs_code  = sel ? b_code  : a_code;
   assign obs_idx   = sel ? b_idx   : a_idx;
   assign obs_err   = sel ? b_err   : a_err;
   assign obs_pass  = sel ? b_pass  : a_pass;

   case_vector_gen u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start & ~sel),
      .vec_valid_o (a_valid),
      .vec_ready_i (ready),
      .vec_code_o  (a_code),
      .vec_idx_o   (a_idx),
      .vec_exp_o   (a_exp),
      .rsp_valid_i (rsp_valid),
      .rsp_y_i     (rsp_y),
      .busy_o      (a_busy),
      .done_o      (a_done),
      .err_cnt_o   (a_err),
`ifdef CASE_GEN_STICKY_ERR_EN
      .err_idx_o   (a_err_idx),
`endif
      .pass_cnt_o  (a_pass)
   );

   case_vector_gen #(
      .GAP_CYCLES (2),
      .NUM_PASSES (2)
   ) u_dut_gap (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start & sel),
      .vec_valid_o (b_valid),
      .vec_ready_i (ready),
      .vec_code_o  (b_code),
      .vec_idx_o   (b_idx),
      .vec_exp_o   (b_exp),
      .rsp_valid_i (rsp_valid),
      .rsp_y_i     (rsp_y),
      .busy_o      (b_busy),
      .done_o      (b_done),
      .err_cnt_o   (b_err),
`ifdef CASE_GEN_STICKY_ERR_EN
      .err_idx_o   (b_err_idx),
`endif
      .pass_cnt_o  (b_pass)
   );

   logic [3:0] codes [16];
   rec_t       vec_tbl [16];
   rec_t       sb [$];
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Start a run, echo each transfer one cycle later (inverted where inv is set), wait for done.
   task automatic run(input int n_rec, input logic [15:0] inv, input int stall_idx,
                      input int stall_len, input int gap_exp, output int nx);
      int   left, last;
      bit   pend, fin;
      logic py;
      rec_t r;
      left = stall_len; last = -1; pend = 0; fin = 0; py = 0; nx = 0;
      for (int i = 0; i < n_rec; i++) sb.push_back(vec_tbl[i % 16]);
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int c = 0; c < 2000 && !fin; c++) begin
         rsp_valid = pend;
         rsp_y     = py;
         pend      = 0;
         ready     = 1'b1;
         if (left > 0 && obs_valid && sb.size() > 0 && 32'(sb[0].idx) == stall_idx) begin
            ready = 1'b0;
            left--;
         end
         @(negedge clk);
         if (obs_done) begin
            fin = 1;
         end else if (obs_valid && ready) begin
            if (sb.size() == 0) begin
               check("xfer_overrun", nx + 1, n_rec);
            end else begin
               r = sb.pop_front();
               check("vec_code", obs_code, r.code);
               check("vec_idx", obs_idx, r.idx);
               check("vec_exp", obs_exp, r.exp);
               pend = 1;
               py   = r.exp ^ inv[r.idx];
               if (gap_exp > 0 && last >= 0) check("gap_spacing", c - last, gap_exp + 1);
               last = c;
            end
            nx++;
         end else if (!ready) begin
            check("stall_hold", {obs_valid, obs_code}, {1'b1, sb[0].code});
         end
         @(posedge clk);
         #1;
      end
      rsp_valid = 1'b0;
      check("run_done", obs_done, 1);
   endtask

   initial begin
      int   nx;
      bit   hit, pend;
      logic py;
      rec_t r;
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0111, 4'b0110,
                4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
      for (int i = 0; i < 16; i++) begin
         vec_tbl[i].idx  = 4'(i);
         vec_tbl[i].code = codes[i];
         vec_tbl[i].exp  = 1'(i % 2);
      end
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; rsp_valid = 1'b0; rsp_y = 1'b0; sel = 1'b0;
      repeat (3) cyc();

      // Reset state
      check("rst_valid", a_valid, 0);
      check("rst_code", a_code, 0);
      check("rst_idx", a_idx, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_err", a_err, 0);
      check("rst_pass", a_pass, 0);
      rst_n = 1'b1;
      cyc();

      // Plain sweep
      run(16, 16'h0000, -1, 0, 0, nx);
      check("sweep_xfers", nx, 16);
      check("sweep_err", a_err, 0);
      check("sweep_pass", a_pass, 1);
      check("sweep_busy", a_busy, 0);

      // Backpressure at idx 5
      run(16, 16'h0000, 5, 3, 0, nx);
      check("bp_xfers", nx, 16);
      check("bp_err", a_err, 0);

      // Wrong responses at idx 2 and 9, then a spurious response in DONE
      run(16, 16'h0204, -1, 0, 0, nx);
      sb.delete();
      rsp_valid = 1'b1; rsp_y = 1'b0;
      cyc();
      rsp_valid = 1'b0;
      @(negedge clk);
`ifdef CASE_GEN_STICKY_ERR_EN
      check("err_xfers", nx, 4);
      check("err_idx", a_err_idx, 2);
      check("err_cnt", a_err, 2);
`else
      check("err_xfers", nx, 16);
      check("err_cnt", a_err, 3);
`endif
      check("err_done_held", a_done, 1);
      cyc();

      // FIFO full without responses, then one response releases exactly one transfer
      for (int i = 0; i < 16; i++) sb.push_back(vec_tbl[i]);
      start = 1'b1; cyc(); start = 1'b0; ready = 1'b1;
      nx = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (a_valid) begin
            r = sb.pop_front();
            check("full_code", a_code, r.code);
            nx++;
         end
         cyc();
      end
      check("full_xfers", nx, 4);
      check("full_valid_low", a_valid, 0);
      rsp_valid = 1'b1; rsp_y = 1'b0;
      cyc();
      rsp_valid = 1'b0;
      nx = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (a_valid) begin
            r = sb.pop_front();
            check("full_more_code", a_code, r.code);
            nx++;
         end
         cyc();
      end
      check("full_one_more", nx, 1);
      check("full_err", a_err, 0);
      rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
      sb.delete();

      // Reset at idx 7 with idx 5 and 6 unanswered
      for (int i = 0; i < 16; i++) sb.push_back(vec_tbl[i]);
      start = 1'b1; cyc(); start = 1'b0; ready = 1'b1;
      hit = 0; pend = 0; py = 0;
      for (int c = 0; c < 60 && !hit; c++) begin
         rsp_valid = pend; rsp_y = py; pend = 0;
         @(negedge clk);
         if (a_valid && sb.size() > 0 && sb[0].idx == 4'd7) begin
            hit = 1;
         end else begin
            if (a_valid) begin
               r = sb.pop_front();
               check("mid_code", a_code, r.code);
               if (r.idx < 4'd5) begin pend = 1; py = r.exp; end
            end
            cyc();
         end
      end
      check("mid_reached_idx7", hit, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", a_valid, 0);
      check("mid_rst_idx", a_idx, 0);
      check("mid_rst_code", a_code, 0);
      check("mid_rst_busy", a_busy, 0);
      check("mid_rst_done", a_done, 0);
      check("mid_rst_err", a_err, 0);
      cyc();
      rst_n = 1'b1; rsp_valid = 1'b0;
      sb.delete();
      cyc();
      run(16, 16'h0000, -1, 0, 0, nx);
      check("restart_xfers", nx, 16);
      check("restart_err", a_err, 0);

      // GAP_CYCLES=2, NUM_PASSES=2 instance
      sel = 1'b1;
      cyc();
      run(32, 16'h0000, -1, 0, 2, nx);
      check("gap_xfers", nx, 32);
      check("gap_pass", obs_pass, 2);
      check("gap_err", obs_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
